// File: rtl/saber_trail_buffer_if.sv
// rtl/saber_trail_buffer_if.sv - read request/response bundle for the saber trail history buffer
interface saber_trail_buffer_if #(
  parameter int AGE_W  = 3,
  parameter int DATA_W = 152
);
  logic              rd_req;
  logic [AGE_W-1:0]  rd_age;
  logic              rd_valid;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;

  // requester side (renderer / hit detection)
  modport master (
    output rd_req,
    output rd_age,
    input  rd_valid,
    input  rd_err,
    input  rd_data
  );

  // buffer side
  modport slave (
    input  rd_req,
    input  rd_age,
    output rd_valid,
    output rd_err,
    output rd_data
  );
endinterface

// File: rtl/saber_trail_buffer.sv
// rtl/saber_trail_buffer.sv - decimated circular history of saber endpoint snapshots, readable by age
module saber_trail_buffer #(
  parameter int NUM_PTS = 4,
  parameter int XY_W    = 12,
  parameter int Z_W     = 14,
  parameter int DEPTH   = 8,
  parameter int DECIM   = 10,
  parameter int TIME_W  = 18,
  localparam int PT_W   = 2 * XY_W + Z_W,
  localparam int DATA_W = NUM_PTS * PT_W,
  localparam int AGE_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [TIME_W-1:0]    curr_time,
  input  logic                 freeze_in,
  input  logic [DATA_W-1:0]    pos_in,
  saber_trail_buffer_if.slave  rd,
  output logic [CNT_W-1:0]     fill_count,
  output logic                 sample_strobe
);

  // a decimation counter needs at least one bit even when every tick is sampled
  localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  // one spare bit so wr_ptr - 1 - age can be formed as a non-negative sum before the modulo
  localparam int IW   = AGE_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [TIME_W-1:0] last_time;
  logic [DC_W-1:0]   decim_cnt;
  logic [AGE_W-1:0]  wr_ptr;

  logic              tick;
  logic              do_sample;
  logic              age_bad;
  logic [IW-1:0]     rd_sum;
  logic [AGE_W-1:0]  rd_idx;

  // tick detection, sample decision and read address; the index avoids any power-of-two wrap
  always_comb begin
    tick      = (curr_time != last_time);
    do_sample = tick && !freeze_in && (decim_cnt == '0);
    age_bad   = (32'(rd.rd_age) >= 32'(fill_count));
    rd_sum    = IW'(wr_ptr) + IW'(DEPTH - 1) - IW'(rd.rd_age);
    rd_idx    = AGE_W'((rd_sum >= IW'(DEPTH)) ? (rd_sum - IW'(DEPTH)) : rd_sum);
  end

  // snapshot storage; not cleared by reset since fill_count hides stale entries
  always_ff @(posedge clk_in) begin
    if (!rst_in && do_sample) begin
      mem[wr_ptr] <= pos_in;
    end
  end

  // time tracking, decimation, write pointer, fill level and registered read port
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_time     <= '0;
      decim_cnt     <= '0;
      wr_ptr        <= '0;
      fill_count    <= '0;
      sample_strobe <= 1'b0;
      rd.rd_valid   <= 1'b0;
      rd.rd_err     <= 1'b0;
      rd.rd_data    <= '0;
    end else begin
      last_time     <= curr_time;
      sample_strobe <= do_sample;

      if (tick && !freeze_in) begin
        decim_cnt <= (decim_cnt == DC_W'(DECIM - 1)) ? '0 : decim_cnt + DC_W'(1);
      end

      if (do_sample) begin
        wr_ptr <= (wr_ptr == AGE_W'(DEPTH - 1)) ? '0 : wr_ptr + AGE_W'(1);
        if (fill_count != CNT_W'(DEPTH)) begin
          fill_count <= fill_count + CNT_W'(1);
        end
      end

      // reads see the state from the start of this cycle, so a same-cycle sample is not visible yet
      if (rd.rd_req) begin
        rd.rd_valid <= 1'b1;
        if (age_bad) begin
          rd.rd_err  <= 1'b1;
          rd.rd_data <= '0;
        end else begin
          rd.rd_err  <= 1'b0;
          rd.rd_data <= mem[rd_idx];
        end
      end else begin
        rd.rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_saber_trail_buffer.sv
// tb/tb_saber_trail_buffer.sv - self-checking bench: two builds (DEPTH 8/DECIM 1, DEPTH 6/DECIM 10) against a queue model
module tb_saber_trail_buffer;
  localparam int NUM_PTS = 4;
  localparam int XY_W    = 12;
  localparam int Z_W     = 14;
  localparam int TIME_W  = 18;
  localparam int PT_W    = 2 * XY_W + Z_W;
  localparam int DATA_W  = NUM_PTS * PT_W;
  localparam int AGE_W   = 3;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [TIME_W-1:0] curr_time = '0;
  logic              freeze_in = 1'b0;
  logic [DATA_W-1:0] pos_in = '0;
  logic              rd_req = 1'b0;
  logic [AGE_W-1:0]  rd_age = '0;

  logic [3:0] fill_a;
  logic [2:0] fill_b;
  logic       strobe_a, strobe_b;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  always #5 clk_in = ~clk_in;

  saber_trail_buffer_if #(.AGE_W(AGE_W), .DATA_W(DATA_W)) ifa ();
  saber_trail_buffer_if #(.AGE_W(AGE_W), .DATA_W(DATA_W)) ifb ();
  assign ifa.rd_req = rd_req;
  assign ifa.rd_age = rd_age;
  assign ifb.rd_req = rd_req;
  assign ifb.rd_age = rd_age;

  saber_trail_buffer #(.NUM_PTS(NUM_PTS), .XY_W(XY_W), .Z_W(Z_W), .DEPTH(8), .DECIM(1), .TIME_W(TIME_W)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .curr_time(curr_time), .freeze_in(freeze_in), .pos_in(pos_in),
    .rd(ifa), .fill_count(fill_a), .sample_strobe(strobe_a));

  saber_trail_buffer #(.NUM_PTS(NUM_PTS), .XY_W(XY_W), .Z_W(Z_W), .DEPTH(6), .DECIM(10), .TIME_W(TIME_W)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .curr_time(curr_time), .freeze_in(freeze_in), .pos_in(pos_in),
    .rd(ifb), .fill_count(fill_b), .sample_strobe(strobe_b));

  // ---------------- behavioural model: newest-first snapshot queues ----------------
  logic [DATA_W-1:0] hist0[$];
  logic [DATA_W-1:0] hist1[$];
  logic [TIME_W-1:0] m_last = '0;
  int                m_ticks [2];
  logic              e_valid [2];
  logic              e_err   [2];
  logic              e_strobe[2];
  logic [DATA_W-1:0] e_data  [2];

  function automatic int hist_size(input int i);
    return (i == 0) ? hist0.size() : hist1.size();
  endfunction

  function automatic logic [DATA_W-1:0] hist_get(input int i, input int age);
    return (i == 0) ? hist0[age] : hist1[age];
  endfunction

  task automatic hist_push(input int i, input logic [DATA_W-1:0] v, input int dep);
    if (i == 0) begin
      hist0.push_front(v);
      if (hist0.size() > dep) void'(hist0.pop_back());
    end else begin
      hist1.push_front(v);
      if (hist1.size() > dep) void'(hist1.pop_back());
    end
  endtask

  task automatic model_step(input int i);
    int dep, dec;
    dep = (i == 0) ? 8 : 6;
    dec = (i == 0) ? 1 : 10;
    if (rst_in) begin
      if (i == 0) hist0.delete(); else hist1.delete();
      m_ticks[i]  = 0;
      e_valid[i]  = 1'b0;
      e_err[i]    = 1'b0;
      e_data[i]   = '0;
      e_strobe[i] = 1'b0;
      return;
    end
    if (rd_req) begin
      e_valid[i] = 1'b1;
      if (int'(rd_age) >= hist_size(i)) begin
        e_err[i]  = 1'b1;
        e_data[i] = '0;
      end else begin
        e_err[i]  = 1'b0;
        e_data[i] = hist_get(i, int'(rd_age));
      end
    end else begin
      e_valid[i] = 1'b0;
    end
    e_strobe[i] = 1'b0;
    if (curr_time != m_last && !freeze_in) begin
      if (m_ticks[i] % dec == 0) begin
        hist_push(i, pos_in, dep);
        e_strobe[i] = 1'b1;
      end
      m_ticks[i] = m_ticks[i] + 1;
    end
  endtask

  always @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) model_step(i);
    m_last = rst_in ? '0 : curr_time;
  end

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle after the first reset: both builds against the model
  always @(negedge clk_in) begin
    if (check_en) begin
      chk("a_valid", int'(ifa.rd_valid), int'(e_valid[0]));
      chk("a_err", int'(ifa.rd_err), int'(e_err[0]));
      chkd("a_data", ifa.rd_data, e_data[0]);
      chk("a_fill", int'(fill_a), hist_size(0));
      chk("a_strobe", int'(strobe_a), int'(e_strobe[0]));
      chk("b_valid", int'(ifb.rd_valid), int'(e_valid[1]));
      chk("b_err", int'(ifb.rd_err), int'(e_err[1]));
      chkd("b_data", ifb.rd_data, e_data[1]);
      chk("b_fill", int'(fill_b), hist_size(1));
      chk("b_strobe", int'(strobe_b), int'(e_strobe[1]));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DATA_W-1:0] mk_pos(input int x0);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_PTS; p++) begin
      v[p*PT_W +: XY_W]          = XY_W'(x0 + p);
      v[p*PT_W + XY_W +: XY_W]   = XY_W'(x0 * 3 + p);
      v[p*PT_W + 2*XY_W +: Z_W]  = Z_W'(x0 * 7 + 5 * p);
    end
    return v;
  endfunction

  task automatic do_reset();
    rst_in    = 1'b1;
    curr_time = '0;
    rd_req    = 1'b0;
    freeze_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic tick(input int x0);
    curr_time = curr_time + 1'b1;
    pos_in    = mk_pos(x0);
    @(negedge clk_in);
  endtask

  // one-cycle read of both builds with literal expectations (x0 of point 0; err implies data 0)
  task automatic rd_chk(input string name, input int age, input int ea, input int xa, input int eb, input int xb);
    rd_req = 1'b1;
    rd_age = AGE_W'(age);
    @(negedge clk_in);
    rd_req = 1'b0;
    chk({name, "_a_valid"}, int'(ifa.rd_valid), 1);
    chk({name, "_a_err"}, int'(ifa.rd_err), ea);
    chk({name, "_a_x0"}, int'(ifa.rd_data[XY_W-1:0]), xa);
    chk({name, "_b_valid"}, int'(ifb.rd_valid), 1);
    chk({name, "_b_err"}, int'(ifb.rd_err), eb);
    chk({name, "_b_x0"}, int'(ifb.rd_data[XY_W-1:0]), xb);
  endtask

  initial begin
    @(posedge clk_in);
    @(negedge clk_in);
    check_en = 1'b1;
    chk("reset_fill_a", int'(fill_a), 0);
    chk("reset_valid_a", int'(ifa.rd_valid), 0);
    rst_in = 1'b0;

    // 1: three ticks, every one sampled in build A
    tick(100); tick(200); tick(300);
    @(negedge clk_in);
    chk("s1_fill_a", int'(fill_a), 3);
    chk("s1_fill_b", int'(fill_b), 1);
    rd_chk("s1_age0", 0, 0, 300, 0, 100);
    rd_chk("s1_age2", 2, 0, 100, 1, 0);

    // 2: 25 ticks, build B samples ticks 1, 11, 21
    do_reset();
    for (int k = 1; k <= 25; k++) tick(k);
    @(negedge clk_in);
    chk("s2_fill_a", int'(fill_a), 8);
    chk("s2_fill_b", int'(fill_b), 3);
    rd_chk("s2_age0", 0, 0, 25, 0, 21);
    rd_chk("s2_age1", 1, 0, 24, 0, 11);
    rd_chk("s2_age2", 2, 0, 23, 0, 1);
    rd_chk("s2_age3", 3, 0, 22, 1, 0);

    // 3: overwrite in A, fill and wrap the non-power-of-two build B
    do_reset();
    for (int k = 1; k <= 12; k++) tick(k);
    chk("s3_fill_a", int'(fill_a), 8);
    rd_chk("s3_age0", 0, 0, 12, 0, 11);
    rd_chk("s3_age7", 7, 0, 5, 1, 0);
    for (int k = 13; k <= 55; k++) tick(k);
    chk("s3_fill_b", int'(fill_b), 6);
    rd_chk("s3_age5", 5, 0, 50, 0, 1);
    rd_chk("s3_age6", 6, 0, 49, 1, 0);
    for (int k = 56; k <= 65; k++) tick(k);
    chk("s3_fill_b_full", int'(fill_b), 6);
    rd_chk("s3_wrap_age0", 0, 0, 65, 0, 61);
    rd_chk("s3_wrap_age5", 5, 0, 60, 0, 11);
    rd_chk("s3_wrap_age7", 7, 0, 58, 1, 0);

    // 4: read issued in the same cycle as sample #4, held for a second cycle
    do_reset();
    tick(10); tick(20); tick(30);
    curr_time = curr_time + 1'b1;
    pos_in    = mk_pos(40);
    rd_req    = 1'b1;
    rd_age    = '0;
    @(negedge clk_in);
    chk("s4_same_valid", int'(ifa.rd_valid), 1);
    chk("s4_same_x0", int'(ifa.rd_data[XY_W-1:0]), 30);
    @(negedge clk_in);
    chk("s4_next_x0", int'(ifa.rd_data[XY_W-1:0]), 40);
    chk("s4_next_b_x0", int'(ifb.rd_data[XY_W-1:0]), 10);
    rd_req = 1'b0;
    @(negedge clk_in);
    chk("s4_idle_valid", int'(ifa.rd_valid), 0);
    chk("s4_hold_x0", int'(ifa.rd_data[XY_W-1:0]), 40);

    // 5: freeze across 30 ticks, then resume
    freeze_in = 1'b1;
    for (int k = 0; k < 30; k++) tick(99);
    chk("s5_frozen_fill_a", int'(fill_a), 4);
    chk("s5_frozen_fill_b", int'(fill_b), 1);
    freeze_in = 1'b0;
    tick(50);
    chk("s5_resume_strobe_a", int'(strobe_a), 1);
    chk("s5_resume_strobe_b", int'(strobe_b), 0);
    for (int k = 51; k <= 55; k++) tick(k);
    tick(60);
    chk("s5_decim_strobe_b", int'(strobe_b), 1);
    @(negedge clk_in);
    chk("s5_fill_b", int'(fill_b), 2);
    rd_chk("s5_age0", 0, 0, 60, 0, 60);

    // 6: reset lands on a pending read
    rd_req    = 1'b1;
    rd_age    = '0;
    rst_in    = 1'b1;
    curr_time = '0;
    @(negedge clk_in);
    chk("s6_valid_a", int'(ifa.rd_valid), 0);
    chk("s6_valid_b", int'(ifb.rd_valid), 0);
    chk("s6_fill_a", int'(fill_a), 0);
    rst_in = 1'b0;
    rd_req = 1'b0;
    rd_chk("s6_empty", 0, 1, 0, 1, 0);
    tick(77);
    chk("s6_first_strobe_a", int'(strobe_a), 1);
    chk("s6_first_strobe_b", int'(strobe_b), 1);
    rd_chk("s6_age0", 0, 0, 77, 0, 77);

    repeat (2) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
